// File: rtl/playseq_pkg.sv
// playseq_pkg: shared constants for the sequence-RAM arbiter.
// State codes, requester indices and default widths.
package playseq_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 4;

   localparam int ESC   = 0;
   localparam int CMP   = 1;
   localparam int PREV  = 2;
   localparam int N_REQ = 3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LE      = 3'd1,
      S_CAPTURA = 3'd2,
      S_ESCREVE = 3'd3,
      S_FIM     = 3'd4
   } state_t;

   typedef logic [N_REQ-1:0] grant_t;

endpackage

// File: rtl/playseq_arb_prio.sv
// playseq_arb_prio: one-hot grant select for the RAM arbiter.
// Write always wins; prefer_prev lets preview beat compare.
module playseq_arb_prio
   import playseq_pkg::*;
(
   input  logic   req_esc,
   input  logic   req_cmp,
   input  logic   req_prev,
   input  logic   prefer_prev,
   output grant_t grant
);

   logic take_cmp;

   // compare wins unless preview is both preferred and asking
   always_comb begin
      take_cmp    = req_cmp && !(prefer_prev && req_prev);
      grant       = '0;
      grant[ESC]  = req_esc;
      grant[CMP]  = !req_esc && take_cmp;
      grant[PREV] = !req_esc && req_prev && !take_cmp;
   end

endmodule

// File: rtl/playseq_ram_arbiter.sv
// playseq_ram_arbiter: shares one sync RAM between a writer and two readers.
// Define PLAYSEQ_ARB_RR_EN for round-robin compare/preview arbitration.
module playseq_ram_arbiter
   import playseq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              req_esc,
   input  logic              req_cmp,
   input  logic              req_prev,
   input  logic [ADDR_W-1:0] end_esc,
   input  logic [ADDR_W-1:0] end_cmp,
   input  logic [ADDR_W-1:0] end_prev,
   input  logic [DATA_W-1:0] dado_esc,
   output logic              done_esc,
   output logic              done_cmp,
   output logic              done_prev,
   output logic [DATA_W-1:0] rdado,
   output logic [ADDR_W-1:0] ram_endereco,
   output logic [DATA_W-1:0] ram_dado,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q,
   output logic              ocupado,
   output logic [2:0]        db_estado
);

   state_t            state;
   grant_t            grant;
   grant_t            grant_q;
   logic              prefer_prev;
   logic [ADDR_W-1:0] sel_addr;

`ifdef PLAYSEQ_ARB_RR_EN
   logic rr_ptr;
   assign prefer_prev = rr_ptr;
`else
   assign prefer_prev = 1'b0;
`endif

   playseq_arb_prio u_prio (
      .req_esc     (req_esc),
      .req_cmp     (req_cmp),
      .req_prev    (req_prev),
      .prefer_prev (prefer_prev),
      .grant       (grant)
   );

   // address of whichever requester is being granted
   always_comb begin
      sel_addr = end_prev;
      if (grant[ESC])
         sel_addr = end_esc;
      else if (grant[CMP])
         sel_addr = end_cmp;
   end

   assign ocupado   = (state != S_IDLE);
   assign db_estado = state;

   // arbiter FSM with registered strobes and datapath
   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= S_IDLE;
         grant_q      <= '0;
         done_esc     <= 1'b0;
         done_cmp     <= 1'b0;
         done_prev    <= 1'b0;
         ram_we       <= 1'b0;
         rdado        <= '0;
         ram_endereco <= '0;
         ram_dado     <= '0;
`ifdef PLAYSEQ_ARB_RR_EN
         rr_ptr       <= 1'b0;
`endif
      end else begin
         done_esc  <= 1'b0;
         done_cmp  <= 1'b0;
         done_prev <= 1'b0;
         ram_we    <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (|grant) begin
                  grant_q      <= grant;
                  ram_endereco <= sel_addr;
                  if (grant[ESC]) begin
                     ram_dado <= dado_esc;
                     ram_we   <= 1'b1;
                     state    <= S_ESCREVE;
                  end else begin
                     state    <= S_LE;
`ifdef PLAYSEQ_ARB_RR_EN
                     rr_ptr   <= grant[CMP];
`endif
                  end
               end
            end
            S_LE: begin
               state <= S_CAPTURA;
            end
            S_CAPTURA: begin
               rdado     <= ram_q;
               done_cmp  <= grant_q[CMP];
               done_prev <= grant_q[PREV];
               state     <= S_FIM;
            end
            S_ESCREVE: begin
               done_esc <= grant_q[ESC];
               state    <= S_FIM;
            end
            S_FIM: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_playseq_ram_arbiter.sv
// tb_playseq_ram_arbiter: random batches of requests against a
// transaction-order model; a monitor pops expected completions.
module tb_playseq_ram_arbiter;
   import playseq_pkg::*;

   localparam int AW = 4;
   localparam int DW = 4;
`ifdef PLAYSEQ_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req_esc = 1'b0;
   logic          req_cmp = 1'b0;
   logic          req_prev = 1'b0;
   logic [AW-1:0] end_esc = '0;
   logic [AW-1:0] end_cmp = '0;
   logic [AW-1:0] end_prev = '0;
   logic [DW-1:0] dado_esc = '0;
   logic          done_esc;
   logic          done_cmp;
   logic          done_prev;
   logic [DW-1:0] rdado;
   logic [AW-1:0] ram_endereco;
   logic [DW-1:0] ram_dado;
   logic          ram_we;
   logic [DW-1:0] ram_q;
   logic          ocupado;
   logic [2:0]    db_estado;

   playseq_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_esc      (req_esc),
      .req_cmp      (req_cmp),
      .req_prev     (req_prev),
      .end_esc      (end_esc),
      .end_cmp      (end_cmp),
      .end_prev     (end_prev),
      .dado_esc     (dado_esc),
      .done_esc     (done_esc),
      .done_cmp     (done_cmp),
      .done_prev    (done_prev),
      .rdado        (rdado),
      .ram_endereco (ram_endereco),
      .ram_dado     (ram_dado),
      .ram_we       (ram_we),
      .ram_q        (ram_q),
      .ocupado      (ocupado),
      .db_estado    (db_estado)
   );

   always #5 clock = ~clock;

   logic [DW-1:0] mem [2**AW] = '{default: '0};

   // the shared RAM: one-cycle synchronous read
   always @(posedge clock) begin
      if (ram_we)
         mem[ram_endereco] <= ram_dado;
      ram_q <= mem[ram_endereco];
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   function automatic void check(string name,
                                 logic [31:0] act,
                                 logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   typedef struct {
      int            who;
      int            cyc;
      logic [DW-1:0] data;
      logic [AW-1:0] addr;
      logic [DW-1:0] hold;
   } exp_t;

   exp_t          expq [$];
   logic [DW-1:0] ref_mem [2**AW] = '{default: '0};
   bit            ptr_prev = 1'b0;
   logic [DW-1:0] last_rd = '0;

   // order of service for a batch of requests raised together
   function automatic void model_batch(bit e, bit c, bit p,
                                       bit cont, int k, int start);
      int   order [$];
      int   t = start;
      int   pick;
      bit   wc = c;
      bit   wp = p;
      exp_t x;
      if (e) order.push_back(ESC);
      if (cont) begin
         for (int i = 0; i < k; i++) begin
            pick = (RR && ptr_prev) ? PREV : CMP;
            order.push_back(pick);
            ptr_prev = (pick == CMP);
         end
      end else begin
         while (wc || wp) begin
            pick = (wc && !(wp && RR && ptr_prev)) ? CMP : PREV;
            order.push_back(pick);
            if (pick == CMP) wc = 0;
            else wp = 0;
            ptr_prev = (pick == CMP);
         end
      end
      foreach (order[i]) begin
         x.who  = order[i];
         x.hold = last_rd;
         if (order[i] == ESC) begin
            x.cyc  = t + 2;
            x.addr = end_esc;
            x.data = dado_esc;
            ref_mem[end_esc] = dado_esc;
         end else begin
            x.cyc  = t + 3;
            x.addr = (order[i] == CMP) ? end_cmp : end_prev;
            x.data = ref_mem[x.addr];
            last_rd = x.data;
         end
         expq.push_back(x);
         t = x.cyc + 1;
      end
   endfunction

   // requesters: hold until own done, then drop
   task automatic run_batch(bit e, bit c, bit p,
                            bit cont, int k, bit early);
      bit oe = e;
      bit oc = c;
      bit op = p;
      int got = 0;
      int budget = 0;
      model_batch(e, c, p, cont, k, cyc);
      req_esc  = e;
      req_cmp  = c;
      req_prev = p;
      while ((oe || oc || op) && budget < 80) begin
         @(negedge clock);
         if (done_esc) oe = 0;
         if (done_cmp || done_prev) got++;
         if (!cont) begin
            if (done_cmp) oc = 0;
            if (done_prev) op = 0;
         end else if (got >= k) begin
            oc = 0;
            op = 0;
         end
         @(posedge clock);
         #1;
         budget++;
         req_esc  = oe;
         req_cmp  = oc;
         req_prev = op && !early;
      end
      if (budget >= 80) begin
         check("batch_timeout", budget, 0);
         req_esc  = 0;
         req_cmp  = 0;
         req_prev = 0;
         expq.delete();
      end
   endtask

   task automatic gap(int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   int   m_nd;
   int   m_who;
   int   we_run = 0;
   exp_t m_x;

   // completion monitor and per-cycle invariants
   always @(negedge clock) begin
      m_nd = int'(done_esc) + int'(done_cmp) + int'(done_prev);
      if (ram_we) begin
         we_run++;
         check("we_in_escreve", db_estado, 3);
      end
      check("ocupado_vs_state", ocupado, db_estado != 0);
      if (m_nd > 0) begin
         check("single_done", m_nd, 1);
         m_who = done_esc ? ESC : (done_cmp ? CMP : PREV);
         if (expq.size() == 0) begin
            check("unexpected_done", m_who, 99);
         end else begin
            m_x = expq.pop_front();
            check("done_who", m_who, m_x.who);
            check("done_cycle", cyc, m_x.cyc);
            if (m_x.who == ESC) begin
               check("we_pulse_len", we_run, 1);
               check("ram_written", mem[m_x.addr], m_x.data);
               check("rdado_hold", rdado, m_x.hold);
            end else begin
               check("rdado", rdado, m_x.data);
            end
         end
         we_run = 0;
      end
      if (!reset) we_run = 0;
   end

   initial begin
      int msk;
      reset = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_state", db_estado, 0);
      check("rst_ocupado", ocupado, 0);
      check("rst_done", {done_esc, done_cmp, done_prev}, 0);
      check("rst_we", ram_we, 0);
      check("rst_rdado", rdado, 0);
      check("rst_addr", ram_endereco, 0);
      check("rst_dado", ram_dado, 0);
      reset = 1;
      gap(1);

      end_esc = 3;
      dado_esc = 4'b0100;
      run_batch(1, 0, 0, 0, 0, 0);
      gap(1);
      end_cmp = 3;
      run_batch(0, 1, 0, 0, 0, 0);
      end_esc = 7;
      dado_esc = 4'b0010;
      end_cmp = 7;
      end_prev = 3;
      run_batch(1, 1, 1, 0, 0, 0);
      gap(2);
      end_cmp = 3;
      end_prev = 7;
      run_batch(0, 1, 1, 1, 6, 0);
      end_prev = 7;
      run_batch(0, 0, 1, 0, 0, 1);
      @(negedge clock);
      check("idle_after_early", db_estado, 0);
      check("free_after_early", ocupado, 0);
      gap(1);

      for (int i = 0; i < 60; i++) begin
         msk = $urandom_range(1, 7);
         end_esc  = $urandom_range(0, 1) ? AW'($urandom_range(0, 3))
                                         : AW'($urandom_range(0, 15));
         end_cmp  = AW'($urandom_range(0, 3));
         end_prev = $urandom_range(0, 1) ? AW'($urandom_range(0, 3))
                                         : AW'($urandom_range(0, 15));
         dado_esc = DW'($urandom_range(0, 15));
         run_batch(msk[0], msk[1], msk[2], 0, 0, 0);
         gap($urandom_range(0, 2));
      end

      end_esc = 5;
      dado_esc = 4'b1000;
      req_esc = 1;
      @(negedge clock);
      check("pre_idle", db_estado, 0);
      gap(1);
      @(negedge clock);
      check("in_escreve", db_estado, 3);
      check("in_escreve_we", ram_we, 1);
      reset = 0;
      @(posedge clock);
      #1;
      req_esc = 0;
      @(negedge clock);
      check("rst_mid_state", db_estado, 0);
      check("rst_mid_we", ram_we, 0);
      check("rst_mid_done", done_esc, 0);
      check("rst_mid_ocupado", ocupado, 0);
      check("rst_mid_rdado", rdado, 0);
      @(posedge clock);
      @(negedge clock);
      check("rst_hold_state", db_estado, 0);
      reset = 1;
      ref_mem[5] = 4'b1000;
      last_rd = '0;
      ptr_prev = 1'b0;
      gap(1);

      for (int i = 0; i < 10; i++) begin
         msk = $urandom_range(1, 7);
         end_esc  = AW'($urandom_range(0, 7));
         end_cmp  = AW'($urandom_range(0, 7));
         end_prev = AW'($urandom_range(0, 7));
         dado_esc = DW'($urandom_range(0, 15));
         run_batch(msk[0], msk[1], msk[2], 0, 0, 0);
      end
      gap(3);
      check("all_done_seen", expq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
